// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the two-port memory arbiter:
//   - arb_state_e   : arbiter FSM states (IDLE, I_BURST, D_BURST)
//   - REQ_I / REQ_D : requester identifiers used by the picker and the top
//   - DEFAULT_BEATS : default number of 32-bit words per cache-line burst
//   - line_off()    : bit position of the first line-address bit
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int DEFAULT_BEATS = 4;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_BURST = 2'd1,
        D_BURST = 2'd2
    } arb_state_e;

    // Byte offset bits of a line: word index within the line plus two
    // byte-select bits of a 32-bit word.
    function automatic int line_off(input int beats);
        return $clog2(beats) + 2;
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// ---------------------------------------------------------------------------
// arb_rr2
// Two-way requester picker for the memory arbiter.
//   Default build: round-robin. A lone requester wins; on a tie the requester
//   that was not granted last wins. The last-grant register resets to REQ_D
//   so the icache wins the first tie after reset.
//   MEM_ARBITER_DPRIO_EN defined: fixed priority, the dcache wins every tie
//   and no last-grant state exists.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  asynchronous active-low reset
//   req_i  in  icache request
//   req_d  in  dcache request
//   take   in  a grant is committed this cycle (records the winner)
//   pick   out winning requester id (REQ_I / REQ_D); REQ_I when idle
// ---------------------------------------------------------------------------
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_i,
    input  logic req_d,
    input  logic take,
    output logic pick
);

`ifdef MEM_ARBITER_DPRIO_EN

    assign pick = req_d ? REQ_D : REQ_I;

    // Clock, reset and history are not needed for fixed priority.
    logic unused_rr;
    assign unused_rr = ^{clk, reset, take, req_i};

`else

    logic last;

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        pick = REQ_I;
        if (req_i && req_d) begin
            pick = (last == REQ_D) ? REQ_I : REQ_D;
        end else if (req_d) begin
            pick = REQ_D;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last <= REQ_D;
        end else if (take) begin
            last <= pick;
        end
    end

`endif

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Arbitrates an icache refill port and a dcache refill/writeback port onto a
// single 32-bit memory port. Each grant runs one full cache-line burst of
// BEATS words; the memory paces each beat with mem_ack. At least one IDLE
// cycle separates consecutive bursts.
// Configuration macro: MEM_ARBITER_DPRIO_EN (defined -> dcache wins ties,
// undefined -> round-robin).
// Parameters:
//   BEATS  words per burst (power of two, 2..16)
//   AW     address width
// Ports:
//   clk, reset                    clock, asynchronous active-low reset
//   i_req, i_addr                 icache refill request and line address
//   i_gnt, i_rvalid, i_rdata,     icache grant, read beat strobe/data,
//   i_done                        last-beat pulse
//   d_req, d_we, d_addr, d_wdata  dcache request, write flag, address, data
//   d_gnt, d_rvalid, d_rdata,     dcache grant, read beat strobe/data,
//   d_wnext, d_done               write beat consumed, last-beat pulse
//   mem_req, mem_we, mem_addr,    memory request, direction, word address,
//   mem_wdata, mem_ack, mem_rdata write data, beat acknowledge, read data
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int BEATS = DEFAULT_BEATS,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [31:0]   i_rdata,
    output logic          i_done,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          d_wnext,
    output logic          d_done,

    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata
);

    localparam int BW  = $clog2(BEATS);
    localparam int OFF = line_off(BEATS);

    arb_state_e         state;
    logic [BW-1:0]      beat;
    logic [AW-OFF-1:0]  base;
    logic               we_q;
    logic               gnt_i_q;
    logic               gnt_d_q;

    logic               any_req;
    logic               take;
    logic               pick;
    logic               busy;
    logic               last_beat;

    assign any_req   = i_req | d_req;
    assign take      = (state == IDLE) && any_req;
    assign busy      = (state != IDLE);
    assign last_beat = (beat == BW'(BEATS - 1));

    arb_rr2 u_pick (
        .clk   (clk),
        .reset (reset),
        .req_i (i_req),
        .req_d (d_req),
        .take  (take),
        .pick  (pick)
    );

    // Burst sequencing. The line base and direction are latched at grant so
    // that requester inputs may change freely while the burst runs; the beat
    // counter only moves on mem_ack and is cleared when the last beat lands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            beat    <= '0;
            base    <= '0;
            we_q    <= 1'b0;
            gnt_i_q <= 1'b0;
            gnt_d_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    beat <= '0;
                    if (any_req) begin
                        if (pick == REQ_D) begin
                            state   <= D_BURST;
                            base    <= d_addr[AW-1:OFF];
                            we_q    <= d_we;
                            gnt_d_q <= 1'b1;
                        end else begin
                            state   <= I_BURST;
                            base    <= i_addr[AW-1:OFF];
                            we_q    <= 1'b0;
                            gnt_i_q <= 1'b1;
                        end
                    end
                end
                I_BURST, D_BURST: begin
                    if (mem_ack) begin
                        if (last_beat) begin
                            state   <= IDLE;
                            beat    <= '0;
                            gnt_i_q <= 1'b0;
                            gnt_d_q <= 1'b0;
                        end else begin
                            beat <= beat + BW'(1);
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    gnt_i_q <= 1'b0;
                    gnt_d_q <= 1'b0;
                end
            endcase
        end
    end

    // The low address bits inside a line are replaced by the beat counter.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[OFF-1:0], d_addr[OFF-1:0]};

    assign i_gnt     = gnt_i_q;
    assign d_gnt     = gnt_d_q;

    assign mem_req   = busy;
    assign mem_we    = busy & we_q;
    assign mem_addr  = {base, beat, 2'b00};
    assign mem_wdata = d_wdata;

    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign i_rvalid  = mem_ack & ~mem_we & gnt_i_q;
    assign d_rvalid  = mem_ack & ~mem_we & gnt_d_q;
    assign d_wnext   = mem_ack &  mem_we & gnt_d_q;

    assign i_done    = gnt_i_q & mem_ack & last_beat;
    assign d_done    = gnt_d_q & mem_ack & last_beat;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter with default parameters (BEATS=4, AW=32).
// Inputs change on the falling edge; outputs are examined 1 time unit later.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

`ifdef MEM_ARBITER_DPRIO_EN
    localparam bit DPRIO = 1'b1;
`else
    localparam bit DPRIO = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt, i_rvalid, i_done;
    logic [31:0] i_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid, d_wnext, d_done;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int total;
    int bad;

    mem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .i_done    (i_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_wnext   (d_wnext),
        .d_done    (d_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Power-on reset: every output must be low while reset is held.
    task automatic test_reset();
        logic [11:0] ctl;
        reset = 1'b0;
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        mem_ack = 0; mem_rdata = 0;
        #3;
        ctl = {i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_wnext, d_done,
               mem_req, mem_we, 3'b000};
        total++;
        if (ctl !== 12'h000) begin
            bad++;
            $display("[TB] FAIL reset_ctl: got %h want 000", ctl);
        end
        total++;
        if (mem_addr !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_addr: got %h want 00000000", mem_addr);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Lone icache refill with an unaligned address and ack every cycle.
    task automatic test_single();
        logic [3:0] got;
        logic [3:0] want;
        @(negedge clk);
        i_req = 1; i_addr = 32'h104; mem_ack = 0;
        #1;
        total++;
        if ({i_gnt, mem_req} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL single_idle: got %b want 00", {i_gnt, mem_req});
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            i_req = 0; mem_ack = 1; mem_rdata = 32'hA000_0000 + k;
            #1;
            got  = {i_gnt, i_rvalid, i_done, mem_we};
            want = {1'b1, 1'b1, (k == 3), 1'b0};
            total++;
            if (got !== want) begin
                bad++;
                $display("[TB] FAIL single_ctl beat%0d: got %b want %b", k, got, want);
            end
            total++;
            if (mem_addr !== 32'h100 + 4 * k) begin
                bad++;
                $display("[TB] FAIL single_addr beat%0d: got %h want %h", k, mem_addr, 32'h100 + 4 * k);
            end
            total++;
            if (i_rdata !== 32'hA000_0000 + k) begin
                bad++;
                $display("[TB] FAIL single_rdata beat%0d: got %h want %h", k, i_rdata, 32'hA000_0000 + k);
            end
        end
        @(negedge clk);
        mem_ack = 0;
        #1;
        total++;
        if ({i_gnt, mem_req, i_done} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL single_end: got %b want 000", {i_gnt, mem_req, i_done});
        end
    endtask

    // Dcache writeback with ack on alternate cycles; requester inputs are
    // scrambled once the burst has started.
    task automatic test_write();
        logic [4:0] got;
        logic [4:0] want;
        @(negedge clk);
        d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hD000_0000; mem_ack = 0;
        #1;
        total++;
        if ({d_gnt, mem_req} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL write_idle: got %b want 00", {d_gnt, mem_req});
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            d_req = 0; d_we = 0; d_addr = 32'hFFF0;
            mem_ack = (c % 2 == 1);
            d_wdata = 32'hD000_0000 + c / 2;
            #1;
            got  = {d_gnt, mem_we, d_wnext, d_rvalid, d_done};
            want = {1'b1, 1'b1, (c % 2 == 1), 1'b0, (c == 7)};
            total++;
            if (got !== want) begin
                bad++;
                $display("[TB] FAIL write_ctl cyc%0d: got %b want %b", c, got, want);
            end
            total++;
            if (mem_addr !== 32'h200 + 4 * (c / 2)) begin
                bad++;
                $display("[TB] FAIL write_addr cyc%0d: got %h want %h", c, mem_addr, 32'h200 + 4 * (c / 2));
            end
            total++;
            if (mem_wdata !== 32'hD000_0000 + c / 2) begin
                bad++;
                $display("[TB] FAIL write_data cyc%0d: got %h want %h", c, mem_wdata, 32'hD000_0000 + c / 2);
            end
        end
        @(negedge clk);
        mem_ack = 0;
        #1;
        total++;
        if ({d_gnt, mem_req, mem_we} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL write_end: got %b want 000", {d_gnt, mem_req, mem_we});
        end
    endtask

    // Dcache refill where d_req drops after the first beat.
    task automatic test_drop();
        logic [3:0] got;
        logic [3:0] want;
        @(negedge clk);
        d_req = 1; d_we = 0; d_addr = 32'h3F8; mem_ack = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 1) d_req = 0;
            mem_ack = 1;
            #1;
            got  = {d_gnt, d_rvalid, d_wnext, d_done};
            want = {1'b1, 1'b1, 1'b0, (k == 3)};
            total++;
            if (got !== want) begin
                bad++;
                $display("[TB] FAIL drop_ctl beat%0d: got %b want %b", k, got, want);
            end
            total++;
            if (mem_addr !== 32'h3F0 + 4 * k) begin
                bad++;
                $display("[TB] FAIL drop_addr beat%0d: got %h want %h", k, mem_addr, 32'h3F0 + 4 * k);
            end
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            mem_ack = 0;
            #1;
            total++;
            if ({d_gnt, mem_req} !== 2'b00) begin
                bad++;
                $display("[TB] FAIL drop_idle%0d: got %b want 00", k, {d_gnt, mem_req});
            end
        end
    endtask

    // Reset asserted during beat 2 of an icache burst, then a fresh burst.
    task automatic test_reset_mid();
        logic [4:0] got;
        @(negedge clk);
        i_req = 1; i_addr = 32'h40; mem_ack = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            mem_ack = 1;
            #1;
            total++;
            if (mem_addr !== 32'h40 + 4 * k) begin
                bad++;
                $display("[TB] FAIL rmid_addr beat%0d: got %h want %h", k, mem_addr, 32'h40 + 4 * k);
            end
        end
        @(negedge clk);
        mem_ack = 1; reset = 0;
        #1;
        got = {i_gnt, i_rvalid, i_done, mem_req, mem_we};
        total++;
        if (got !== 5'b0) begin
            bad++;
            $display("[TB] FAIL rmid_abort: got %b want 00000", got);
        end
        total++;
        if (mem_addr !== 32'h0) begin
            bad++;
            $display("[TB] FAIL rmid_abort_addr: got %h want 00000000", mem_addr);
        end
        @(negedge clk);
        reset = 1; mem_ack = 0; i_req = 1; i_addr = 32'h80;
        #1;
        total++;
        if ({i_gnt, mem_req} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL rmid_idle: got %b want 00", {i_gnt, mem_req});
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            i_req = 0; mem_ack = 1;
            #1;
            total++;
            if ({i_gnt, i_done} !== {1'b1, (k == 3)}) begin
                bad++;
                $display("[TB] FAIL rmid_ctl beat%0d: got %b want %b", k, {i_gnt, i_done}, {1'b1, (k == 3)});
            end
            total++;
            if (mem_addr !== 32'h80 + 4 * k) begin
                bad++;
                $display("[TB] FAIL rmid_addr2 beat%0d: got %h want %h", k, mem_addr, 32'h80 + 4 * k);
            end
        end
        @(negedge clk);
        mem_ack = 0;
    endtask

    // Both requesters held high through three arbitrations straight after
    // reset. Round-robin expects I, D, I; fixed priority expects D, D, D.
    task automatic test_tie();
        bit         exp_d;
        logic [31:0] exp_addr;
        logic [4:0] got;
        logic [4:0] want;
        reset = 0;
        @(negedge clk);
        reset = 1;
        i_req = 1; d_req = 1; d_we = 0; i_addr = 32'h500; d_addr = 32'h300; mem_ack = 0;
        #1;
        total++;
        if ({i_gnt, d_gnt, mem_req} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL tie_start: got %b want 000", {i_gnt, d_gnt, mem_req});
        end
        exp_d = DPRIO;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                mem_ack = 1;
                #1;
                got  = {i_gnt, d_gnt, i_rvalid, d_rvalid, (i_done | d_done)};
                want = {~exp_d, exp_d, ~exp_d, exp_d, (k == 3)};
                total++;
                if (got !== want) begin
                    bad++;
                    $display("[TB] FAIL tie_ctl round%0d beat%0d: got %b want %b", r, k, got, want);
                end
                exp_addr = (exp_d ? 32'h300 : 32'h500) + 4 * k;
                total++;
                if (mem_addr !== exp_addr) begin
                    bad++;
                    $display("[TB] FAIL tie_addr round%0d beat%0d: got %h want %h", r, k, mem_addr, exp_addr);
                end
            end
            @(negedge clk);
            mem_ack = 0;
            #1;
            total++;
            if ({i_gnt, d_gnt, mem_req} !== 3'b000) begin
                bad++;
                $display("[TB] FAIL tie_gap round%0d: got %b want 000", r, {i_gnt, d_gnt, mem_req});
            end
            exp_d = DPRIO ? 1'b1 : ~exp_d;
        end
        i_req = 0; d_req = 0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_write();
        test_drop();
        test_reset_mid();
        test_tie();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
